// File: rtl/layer_input_buffer_if.sv
// Serial sample input and result output handshakes
// for the layer input buffer.
interface layer_input_buffer_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/layer_input_buffer.sv
// Staging buffer for one neuron layer: serial fill,
// parallel present, feedback capture, serial drain.
module layer_input_buffer #(
  parameter int DATA_W   = 8,
  parameter int N_CH     = 4,
  parameter int N_LAYERS = 3,
  localparam int LW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1,
  localparam int CW = $clog2(N_CH + 1)
) (
  input  logic                   clk,
  input  logic                   rstn,
  layer_input_buffer_if.slave    bus,
  input  logic [N_CH*DATA_W-1:0] neuron_out,
  input  logic                   fb_load,
  input  logic                   drain_start,
  input  logic                   clear,
  output logic [N_CH*DATA_W-1:0] layer_in,
  output logic                   layer_valid,
  output logic [LW-1:0]          layer_idx,
  output logic                   last_layer
);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] FULL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     count;
  logic [LW-1:0]     idx;
  logic [DATA_W-1:0] slot [N_CH];

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      state <= FILL;
      count <= '0;
      idx   <= '0;
      for (int i = 0; i < N_CH; i++)
        slot[i] <= '0;
    end else begin
      case (state)
        FILL: begin
          if (bus.in_valid) begin
            slot[0] <= bus.in_data;
            for (int i = 1; i < N_CH; i++)
              slot[i] <= slot[i-1];
            count <= count + 1'b1;
            if (count == CW'(N_CH - 1))
              state <= FULL;
          end
        end
        FULL: begin
          // fb_load wins; a coincident drain_start is dropped
          if (fb_load) begin
            for (int i = 0; i < N_CH; i++)
              slot[i] <= neuron_out[i*DATA_W +: DATA_W];
            if (!last_layer)
              idx <= idx + 1'b1;
          end else if (drain_start) begin
            state <= DRAIN;
            count <= CW'(N_CH);
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            slot[0] <= '0;
            for (int i = 1; i < N_CH; i++)
              slot[i] <= slot[i-1];
            count <= count - 1'b1;
            if (count == CW'(1)) begin
              state <= FILL;
              count <= '0;
              idx   <= '0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.in_ready  = rstn && (state == FILL);
  assign layer_valid   = rstn && (state == FULL);
  assign bus.out_valid = rstn && (state == DRAIN);
  assign bus.out_data  = bus.out_valid ? slot[N_CH-1] : '0;
  assign layer_idx     = idx;
  assign last_layer    = (idx == LW'(N_LAYERS - 1));

  always_comb begin
    layer_in = '0;
    if (rstn)
      for (int i = 0; i < N_CH; i++)
        layer_in[i*DATA_W +: DATA_W] = slot[i];
  end

endmodule

// File: tb/tb_layer_input_buffer.sv
// Bench for layer_input_buffer: directed table, corner
// sequences and random traffic against a queue model.
module tb_layer_input_buffer;
  localparam int DW = 8;
  localparam int NC = 4;
  localparam int NL = 3;

  logic        clk = 0;
  logic        rstn;
  logic [31:0] neuron_out;
  logic        fb_load, drain_start, clear;
  logic [31:0] layer_in;
  logic        layer_valid;
  logic [1:0]  layer_idx;
  logic        last_layer;

  int n_cmp = 0;
  int n_err = 0;

  layer_input_buffer_if #(.DATA_W(DW)) bus ();

  layer_input_buffer #(
    .DATA_W(DW), .N_CH(NC), .N_LAYERS(NL)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .neuron_out(neuron_out), .fb_load(fb_load),
    .drain_start(drain_start), .clear(clear),
    .layer_in(layer_in), .layer_valid(layer_valid),
    .layer_idx(layer_idx), .last_layer(last_layer)
  );

  always #5 clk = ~clk;

  // model: mode 0 fill, 1 full, 2 drain; m_q[i] is slot i
  int         m_mode;
  int         m_cnt;
  int         m_idx;
  logic [7:0] m_q [$];

  task automatic model_reset();
    m_mode = 0;
    m_cnt  = 0;
    m_idx  = 0;
    m_q    = {};
    repeat (NC) m_q.push_back(8'h00);
  endtask

  task automatic model_next();
    if (!rstn || clear) begin
      model_reset();
      return;
    end
    if (m_mode == 0) begin
      if (bus.in_valid) begin
        m_q.push_front(bus.in_data);
        void'(m_q.pop_back());
        m_cnt++;
        if (m_cnt == NC) m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (fb_load) begin
        for (int i = 0; i < NC; i++)
          m_q[i] = neuron_out[i*8 +: 8];
        if (m_idx < NL - 1) m_idx++;
      end else if (drain_start) begin
        m_mode = 2;
        m_cnt  = NC;
      end
    end else begin
      if (bus.out_ready) begin
        m_q.push_front(8'h00);
        void'(m_q.pop_back());
        m_cnt--;
        if (m_cnt == 0) begin
          m_mode = 0;
          m_idx  = 0;
        end
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, a, e, $time);
    end
  endtask

  task automatic check_model();
    logic [31:0] li;
    li = '0;
    if (rstn)
      for (int i = 0; i < NC; i++) li[i*8 +: 8] = m_q[i];
    chk("in_ready", 32'(bus.in_ready), 32'(rstn && m_mode == 0));
    chk("layer_valid", 32'(layer_valid), 32'(rstn && m_mode == 1));
    chk("out_valid", 32'(bus.out_valid), 32'(rstn && m_mode == 2));
    chk("out_data", 32'(bus.out_data),
        (rstn && m_mode == 2) ? 32'(m_q[NC-1]) : 32'h0);
    chk("layer_in", layer_in, li);
    chk("layer_idx", 32'(layer_idx), 32'(m_idx));
    chk("last_layer", 32'(last_layer), 32'(m_idx == NL - 1));
  endtask

  task automatic pre();
    @(negedge clk);
    check_model();
  endtask

  task automatic post();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
    fb_load = 0; drain_start = 0; clear = 0; neuron_out = 0;
  endtask

  task automatic fill(int n, logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      bus.in_valid = 1;
      bus.in_data  = base + 8'(k);
      pre(); post();
    end
    idle();
  endtask

  typedef struct {
    logic        iv;
    logic [7:0]  d;
    logic        fb;
    logic        ds;
    logic        ordy;
    logic [31:0] nout;
    logic        e_lv;
    logic [1:0]  e_idx;
    logic        e_ov;
    logic [7:0]  e_od;
  } vec_t;

  vec_t tv [16];

  initial begin
    tv[0]  = '{1, 8'h11, 0, 0, 0, 0, 0, 0, 0, 8'h00};
    tv[1]  = '{1, 8'h22, 0, 0, 0, 0, 0, 0, 0, 8'h00};
    tv[2]  = '{1, 8'h33, 0, 0, 0, 0, 0, 0, 0, 8'h00};
    tv[3]  = '{1, 8'h44, 0, 0, 0, 0, 0, 0, 0, 8'h00};
    tv[4]  = '{1, 8'h55, 0, 0, 0, 0, 1, 0, 0, 8'h00};
    tv[5]  = '{0, 8'h00, 1, 0, 0, 32'hA3A2A1A0, 1, 0, 0, 8'h00};
    tv[6]  = '{0, 8'h00, 1, 0, 0, 32'hB3B2B1B0, 1, 1, 0, 8'h00};
    tv[7]  = '{0, 8'h00, 1, 0, 0, 32'hC3C2C1C0, 1, 2, 0, 8'h00};
    tv[8]  = '{0, 8'h00, 0, 1, 0, 0, 1, 2, 0, 8'h00};
    tv[9]  = '{0, 8'h00, 0, 0, 1, 0, 0, 2, 1, 8'hC3};
    tv[10] = '{1, 8'h77, 0, 0, 0, 0, 0, 2, 1, 8'hC2};
    tv[11] = '{0, 8'h00, 0, 0, 1, 0, 0, 2, 1, 8'hC2};
    tv[12] = '{0, 8'h00, 0, 0, 1, 0, 0, 2, 1, 8'hC1};
    tv[13] = '{0, 8'h00, 0, 0, 0, 0, 0, 2, 1, 8'hC0};
    tv[14] = '{0, 8'h00, 0, 0, 1, 0, 0, 2, 1, 8'hC0};
    tv[15] = '{0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00};

    idle();
    rstn = 0;
    model_reset();
    @(posedge clk); #1;
    pre(); post();
    rstn = 1;

    for (int k = 0; k < 16; k++) begin
      bus.in_valid  = tv[k].iv;
      bus.in_data   = tv[k].d;
      fb_load       = tv[k].fb;
      drain_start   = tv[k].ds;
      bus.out_ready = tv[k].ordy;
      neuron_out    = tv[k].nout;
      pre();
      chk("tv_lv", 32'(layer_valid), 32'(tv[k].e_lv));
      chk("tv_idx", 32'(layer_idx), 32'(tv[k].e_idx));
      chk("tv_ov", 32'(bus.out_valid), 32'(tv[k].e_ov));
      chk("tv_od", 32'(bus.out_data), 32'(tv[k].e_od));
      if (k == 4)
        chk("tv_full_slots", layer_in, 32'h11223344);
      post();
    end
    idle();

    // fb_load and drain_start together: capture only
    fill(4, 8'h01);
    fb_load = 1; drain_start = 1;
    neuron_out = 32'hD3D2D1D0;
    pre(); post();
    idle();
    pre();
    chk("fbds_lv", 32'(layer_valid), 32'h1);
    chk("fbds_ov", 32'(bus.out_valid), 32'h0);
    chk("fbds_slots", layer_in, 32'hD3D2D1D0);
    post();
    clear = 1;
    pre(); post();
    idle();
    drain_start = 1;
    pre(); post();
    idle();
    pre();
    chk("ds_fill_ov", 32'(bus.out_valid), 32'h0);
    chk("ds_fill_ir", 32'(bus.in_ready), 32'h1);
    post();

    // clear after two drained words
    fill(4, 8'h60);
    drain_start = 1;
    pre(); post();
    idle();
    bus.out_ready = 1;
    pre(); post();
    pre(); post();
    clear = 1;
    bus.in_valid = 1; bus.in_data = 8'hEE;
    pre(); post();
    idle();
    pre();
    chk("clr_ov", 32'(bus.out_valid), 32'h0);
    chk("clr_ir", 32'(bus.in_ready), 32'h1);
    chk("clr_slots", layer_in, 32'h0);
    post();

    // reset during fill after two samples
    fill(2, 8'h90);
    rstn = 0;
    bus.in_valid = 1; bus.in_data = 8'h99;
    pre();
    chk("rst_ir", 32'(bus.in_ready), 32'h0);
    chk("rst_li", layer_in, 32'h0);
    post();
    rstn = 1;
    idle();
    fill(3, 8'hA0);
    pre();
    chk("rst_cnt_ir", 32'(bus.in_ready), 32'h1);
    chk("rst_cnt_lv", 32'(layer_valid), 32'h0);
    post();

    // random traffic
    for (int k = 0; k < 600; k++) begin
      bus.in_valid  = 1'($urandom % 2);
      bus.in_data   = 8'($urandom);
      fb_load       = ($urandom % 6) == 0;
      drain_start   = ($urandom % 5) == 0;
      clear         = ($urandom % 60) == 0;
      bus.out_ready = 1'($urandom % 2);
      neuron_out    = $urandom;
      rstn          = ($urandom % 100) != 0;
      pre(); post();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
